// File: rtl/ysyx_23060201_seq_pkg.sv
// ysyx_23060201_seq_pkg: shared defines for the NPC core (opcodes, sequencer state codes, reset PC)
package ysyx_23060201_seq_pkg;
    localparam logic [31:0] SEQ_RESET_PC = 32'h8000_0000;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] ST_IF_REQ = 3'd0;
    localparam logic [2:0] ST_IF_WAIT = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_LS_REQ = 3'd3;
    localparam logic [2:0] ST_LS_WAIT = 3'd4;
    localparam logic [2:0] ST_WB = 3'd5;
    localparam logic [2:0] ST_HALT = 3'd6;
    typedef enum logic [2:0] {
        IF_REQ = ST_IF_REQ,
        IF_WAIT = ST_IF_WAIT,
        EXEC = ST_EXEC,
        LS_REQ = ST_LS_REQ,
        LS_WAIT = ST_LS_WAIT,
        WB = ST_WB,
        HALT = ST_HALT
    } seq_state_e;
endpackage

// File: rtl/ysyx_23060201_perf_cnt.sv
// ysyx_23060201_perf_cnt: cycle/instret counters, compiled only when SEQ_PERF_EN is defined
`ifdef SEQ_PERF_EN
module ysyx_23060201_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cyc_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= clr ? '0 : cyc_cnt + CNT_W'(cyc_inc);
            ret_cnt <= clr ? '0 : ret_cnt + CNT_W'(ret_inc);
        end
    end
endmodule
`endif

// File: rtl/ysyx_23060201_seq.sv
// ysyx_23060201_seq: multi-cycle fetch/exec/LSU sequencer; perf counters only with SEQ_PERF_EN
module ysyx_23060201_seq
    import ysyx_23060201_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(SEQ_RESET_PC),
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_addr,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_data,
    output logic [31:0]      inst,
    input  logic [XLEN-1:0]  exu_dnpc,
    input  logic             exu_is_mem,
    input  logic             exu_gpr_wen,
    input  logic             exu_halt,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    output logic             gpr_wen,
    output logic [XLEN-1:0]  pc,
    output logic             commit,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    seq_state_e state_q, state_d;
    logic [XLEN-1:0] npc_q;
    logic wen_q;
    logic halt_seen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_REQ;
            pc <= RESET_PC;
            npc_q <= RESET_PC;
            inst <= '0;
            wen_q <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IF_WAIT && ifu_rsp_valid) inst <= ifu_rsp_data;
            if (state_q == EXEC) npc_q <= exu_dnpc;
            if (state_q == EXEC) wen_q <= exu_gpr_wen;
            if (state_q == WB) pc <= npc_q;
            halt_seen_q <= state_q == HALT;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_REQ:  state_d = ifu_req_ready ? IF_WAIT : IF_REQ;
            IF_WAIT: state_d = ifu_rsp_valid ? EXEC : IF_WAIT;
            EXEC:    state_d = exu_halt ? HALT : exu_is_mem ? LS_REQ : WB;
            LS_REQ:  state_d = lsu_req_ready ? LS_WAIT : LS_REQ;
            LS_WAIT: state_d = lsu_rsp_valid ? WB : LS_WAIT;
            WB:      state_d = IF_REQ;
            default: state_d = state_q;
        endcase
    end

    // write enable is latched in EXEC so no strobe depends combinationally on an input
    assign ifu_req_valid = state_q == IF_REQ;
    assign lsu_req_valid = state_q == LS_REQ;
    assign gpr_wen = state_q == WB && wen_q;
    assign halted = state_q == HALT;
    assign commit = state_q == WB || (state_q == HALT && !halt_seen_q);
    assign ifu_addr = pc;

`ifdef SEQ_PERF_EN
    ysyx_23060201_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .cyc_inc (!halted),
        .ret_inc (commit),
        .cyc_cnt (cycle_cnt),
        .ret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_23060201_seq.sv
// tb_ysyx_23060201_seq: randomized handshake bench against a cycle-timeline model of the sequencer
module tb_ysyx_23060201_seq;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    logic clk, rst;
    logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rsp_data, inst, exu_dnpc, pc;
    logic exu_is_mem, exu_gpr_wen, exu_halt;
    logic lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic gpr_wen, commit, halted;
    logic [63:0] cycle_cnt, instret_cnt;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc, m_inst;
    logic [63:0] m_cyc, m_ret;

    ysyx_23060201_seq dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .inst(inst),
        .exu_dnpc(exu_dnpc), .exu_is_mem(exu_is_mem), .exu_gpr_wen(exu_gpr_wen), .exu_halt(exu_halt),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .gpr_wen(gpr_wen), .pc(pc), .commit(commit), .halted(halted),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_cnt(input string name);
        logic [63:0] e_cc, e_ir;
`ifdef SEQ_PERF_EN
        e_cc = m_cyc;
        e_ir = m_ret;
`else
        e_cc = 0;
        e_ir = 0;
`endif
        checks++;
        if (cycle_cnt !== e_cc || instret_cnt !== e_ir) begin
            errors++;
            $display("FAIL %s_cnt cycle %0d instret %0d want %0d %0d", name, cycle_cnt, instret_cnt, e_cc, e_ir);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ifu_req_valid, lsu_req_valid, commit, gpr_wen, halted} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000", {ifu_req_valid, lsu_req_valid, commit, gpr_wen, halted});
        end
        checks++;
        if (pc !== RESET_PC || ifu_addr !== RESET_PC || inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs pc %h addr %h inst %h want %h %h 0", pc, ifu_addr, inst, RESET_PC, RESET_PC);
        end
        m_cyc = 0;
        m_ret = 0;
        check_cnt("reset");
        @(negedge clk);
        rst = 1'b1;
        m_pc = RESET_PC;
        m_inst = 0;
    endtask

    // One instruction, described as a timeline of handshake phases; abort_at>0 resets mid-flight
    task automatic run_insn(input int iw, input int rw, input bit mem, input int lw, input int lrw,
                            input bit wen, input logic [31:0] dnpc, input bit halt,
                            input logic [31:0] word, input int abort_at);
        int f_end, w_end, e_c, lq_end, lw_end, lat;
        bit m;
        logic [4:0] e_ctl, a_ctl;
        m = mem && !halt;
        f_end = iw + 1;
        w_end = f_end + rw + 1;
        e_c = w_end + 1;
        lq_end = e_c + lw + 1;
        lw_end = lq_end + lrw + 1;
        lat = m ? lw_end + 1 : e_c + 1;
        for (int c = 1; c <= lat; c++) begin
            e_ctl = {c <= f_end, m && c > e_c && c <= lq_end, c == lat, c == lat && wen && !halt, c == lat && halt};
            a_ctl = {ifu_req_valid, lsu_req_valid, commit, gpr_wen, halted};
            checks++;
            if (a_ctl !== e_ctl) begin
                errors++;
                $display("FAIL ctrl cyc %0d got %b want %b", c, a_ctl, e_ctl);
            end
            checks++;
            if (pc !== m_pc || ifu_addr !== m_pc) begin
                errors++;
                $display("FAIL pc cyc %0d pc %h addr %h want %h", c, pc, ifu_addr, m_pc);
            end
            checks++;
            if (inst !== (c >= e_c ? word : m_inst)) begin
                errors++;
                $display("FAIL inst cyc %0d got %h want %h", c, inst, c >= e_c ? word : m_inst);
            end
            check_cnt("insn");
            ifu_req_ready = c == f_end ? 1'b1 : c < f_end ? 1'b0 : 1'($urandom);
            ifu_rsp_valid = c == w_end || (c == f_end && 1'($urandom));
            ifu_rsp_data = c == w_end ? word : $urandom;
            lsu_req_ready = (m && c == lq_end) ? 1'b1 : (m && c > e_c && c < lq_end) ? 1'b0 : 1'($urandom);
            lsu_rsp_valid = m && (c == lw_end || (c == lq_end && 1'($urandom)));
            exu_dnpc = c >= e_c ? dnpc : $urandom;
            exu_is_mem = c >= e_c ? mem : 1'($urandom);
            exu_gpr_wen = c >= e_c ? wen : 1'($urandom);
            exu_halt = c >= e_c ? halt : 1'b0;
            if (c == abort_at) begin
                do_reset();
                return;
            end
            @(negedge clk);
            if (!(halt && c == lat)) m_cyc++;
        end
        m_ret++;
        m_inst = word;
        if (!halt) m_pc = dnpc;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_addi();
        run_insn(0, 0, 0, 0, 0, 1, m_pc + 32'd4, 0, 32'h0010_0093, 0);
        checks++;
        if (pc !== 32'h8000_0004) begin
            errors++;
            $display("FAIL addi_pc got %h want 80000004", pc);
        end
    endtask

    task automatic test_ifu_stall();
        run_insn(5, 0, 0, 0, 0, 1, m_pc + 32'd4, 0, $urandom, 0);
        run_insn(2, 3, 0, 0, 0, 0, m_pc + 32'd4, 0, $urandom, 0);
    endtask

    task automatic test_store_delay();
        run_insn(0, 0, 1, 0, 3, 0, m_pc + 32'd4, 0, 32'h00a1_2023, 0);
        run_insn(0, 0, 1, 2, 1, 1, m_pc + 32'd4, 0, 32'h0001_2083, 0);
    endtask

    task automatic test_wrap();
        run_insn(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0000_006f, 0);
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL jump_pc got %h want fffffffc", pc);
        end
        run_insn(0, 0, 0, 0, 0, 0, m_pc + 32'd4, 0, 32'h0000_0013, 0);
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc got %h want 00000000", pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_insn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 1) != 0) ? m_pc + 32'd4 : $urandom,
                     0, $urandom, 0);
    endtask

    task automatic test_reset_mid();
        run_insn(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, $urandom, 0);
        run_insn(0, 0, 1, 0, 3, 1, m_pc + 32'd4, 0, $urandom, 5);
        run_insn(0, 0, 0, 0, 0, 1, m_pc + 32'd4, 0, $urandom, 0);
        run_insn(0, 0, 1, 3, 0, 0, m_pc + 32'd8, 0, $urandom, 5);
        run_insn(1, 1, 1, 1, 1, 1, m_pc + 32'd4, 0, $urandom, 0);
    endtask

    task automatic test_halt();
        run_insn(1, 0, 1, 0, 0, 1, 32'hDEAD_BEE0, 1, 32'h0010_0073, 0);
        for (int i = 0; i < 6; i++) begin
            ifu_req_ready = 1'b1;
            ifu_rsp_valid = 1'b1;
            lsu_req_ready = 1'b1;
            lsu_rsp_valid = 1'b1;
            checks++;
            if ({ifu_req_valid, lsu_req_valid, commit, gpr_wen, halted} !== 5'b00001) begin
                errors++;
                $display("FAIL halt_ctrl idle %0d got %b want 00001", i, {ifu_req_valid, lsu_req_valid, commit, gpr_wen, halted});
            end
            checks++;
            if (pc !== m_pc) begin
                errors++;
                $display("FAIL halt_pc got %h want %h", pc, m_pc);
            end
            check_cnt("halt");
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = '0;
        {exu_is_mem, exu_gpr_wen, exu_halt} = '0;
        ifu_rsp_data = '0;
        exu_dnpc = '0;
        m_pc = RESET_PC;
        m_inst = 0;
        m_cyc = 0;
        m_ret = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_ifu_stall();
        test_store_delay();
        test_wrap();
        test_random();
        test_reset_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
